lsu_subword: RTL and testbench

Load/store initiator between the core's MEM stage and the data port of the unified word-addressed memory. The memory only reads and writes whole aligned 32-bit words, so this block adds RV32I byte and halfword access on top of it. Loads get lane extraction plus sign or zero extension. Sub-word stores use a read-modify-write sequence. Misaligned or illegal accesses return an error response and never touch memory.

---
 rtl/lsu_subword.sv | 219 +++++++++++++++++++++
 tb/tb_lsu_subword.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_subword.sv
// Sub-word load/store initiator: RV32I B/H/W accesses on top of a word-only memory.
// Loads extract and extend one lane; sub-word stores run a read-modify-write.

package lsu_subword_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic        enable_t;

    typedef struct packed {
        addr_t      addr;
        enable_t    we;
        logic [2:0] funct3;
        data_t      wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;
endpackage

// One byte lane of the store merge: either keep the old byte or take the new one.
module lsu_byte_lane (
    input  logic       en,
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    output logic [7:0] merged
);
    assign merged = en ? new_byte : old_byte;
endmodule

module lsu_subword
    import lsu_subword_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  enable_t req_valid_i,
    output enable_t req_ready_o,
    input  addr_t   req_addr_i,
    input  enable_t req_we_i,
    input  logic [2:0] req_funct3_i,
    input  data_t   req_wdata_i,
    output enable_t resp_valid_o,
    input  enable_t resp_ready_i,
    output data_t   resp_rdata_o,
    output enable_t resp_err_o,
    output addr_t   dmem_addr_o,
    output enable_t dmem_ren_o,
    input  data_t   dmem_rdata_i,
    output enable_t dmem_wen_o,
    output data_t   dmem_wdata_o
);
    localparam int NUM_LANES = 4;

    state_t state, state_next;
    req_t   req;
    data_t  word;
    data_t  rdata;
    logic   err;

    logic   accept;
    logic   bad;
    data_t  lane_data;
    data_t  load_ext;
    data_t  store_data;
    data_t  merged_word;
    logic [NUM_LANES-1:0] byte_en;

    function automatic logic bad_access(input logic [2:0] f3, input logic we, input logic [1:0] a);
        logic b;
        case (f3)
            3'b000:         b = 1'b0;
            3'b001:         b = a[0];
            3'b010:         b = (a != 2'b00);
            3'b100, 3'b101: b = we;
            default:        b = 1'b1;
        endcase
        return b;
    endfunction

    assign accept = req_valid_i && (state == IDLE);
    assign bad    = bad_access(req_funct3_i, req_we_i, req_addr_i[1:0]);

    // Lane selection by shifting the word down; halfwords are already known aligned here.
    assign lane_data = dmem_rdata_i >> {req.addr[1:0], 3'b000};

    always_comb begin
        load_ext = dmem_rdata_i;
        case (req.funct3)
            3'b000:  load_ext = {{24{lane_data[7]}},  lane_data[7:0]};
            3'b001:  load_ext = {{16{lane_data[15]}}, lane_data[15:0]};
            3'b100:  load_ext = {24'h0, lane_data[7:0]};
            3'b101:  load_ext = {16'h0, lane_data[15:0]};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    always_comb begin
        byte_en    = 4'b1111;
        store_data = req.wdata;
        case (req.funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << req.addr[1:0];
                store_data = {4{req.wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = req.addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{req.wdata[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_data = req.wdata;
            end
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            lsu_byte_lane u_lane (
                .en       (byte_en[g]),
                .old_byte (dmem_rdata_i[8*g +: 8]),
                .new_byte (store_data[8*g +: 8]),
                .merged   (merged_word[8*g +: 8])
            );
        end
    endgenerate

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bad)
                        state_next = RESP;
                    else if (req_we_i && req_funct3_i == 3'b010)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:    state_next = req.we ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = resp_ready_i ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            req   <= '0;
            word  <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req   <= '{addr: req_addr_i, we: req_we_i,
                                   funct3: req_funct3_i, wdata: req_wdata_i};
                        err   <= bad;
                        rdata <= '0;
                        // A full-word store writes the request data unchanged.
                        word  <= req_wdata_i;
                    end
                end
                READ: begin
                    if (req.we)
                        word <= merged_word;
                    else
                        rdata <= load_ext;
                end
                default: ;
            endcase
        end
    end

    // Outputs are gated by rst so an aborted transaction cannot issue a write in the reset cycle.
    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_rdata_o = '0;
        resp_err_o   = 1'b0;
        dmem_addr_o  = '0;
        dmem_ren_o   = 1'b0;
        dmem_wen_o   = 1'b0;
        dmem_wdata_o = '0;
        if (!rst) begin
            case (state)
                IDLE: req_ready_o = 1'b1;
                READ: begin
                    dmem_ren_o  = 1'b1;
                    dmem_addr_o = {req.addr[31:2], 2'b00};
                end
                WRITE: begin
                    dmem_wen_o   = 1'b1;
                    dmem_addr_o  = {req.addr[31:2], 2'b00};
                    dmem_wdata_o = word;
                end
                RESP: begin
                    resp_valid_o = 1'b1;
                    resp_rdata_o = rdata;
                    resp_err_o   = err;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(dmem_ren_o && dmem_wen_o));
        end
    end
endmodule

// File: tb/tb_lsu_subword.sv
// Directed bench for lsu_subword: vector table of loads/stores/errors against a word memory,
// plus hand sequences for response backpressure and reset in the middle of a read-modify-write.

module tb_lsu_subword;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dmem_addr;
    logic        dmem_ren;
    logic [31:0] dmem_rdata;
    logic        dmem_wen;
    logic [31:0] dmem_wdata;

    logic [31:0] mem [0:255];
    int nvec = 0;
    int nerr = 0;
    int wen_total = 0;

    lsu_subword dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .dmem_addr_o  (dmem_addr),
        .dmem_ren_o   (dmem_ren),
        .dmem_rdata_i (dmem_rdata),
        .dmem_wen_o   (dmem_wen),
        .dmem_wdata_o (dmem_wdata)
    );

    always #5 clk = ~clk;

    assign dmem_rdata = mem[dmem_addr[9:2]];

    always @(posedge clk) begin
        if (dmem_wen) begin
            mem[dmem_addr[9:2]] <= dmem_wdata;
            wen_total <= wen_total + 1;
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_ren;
        int          exp_wen;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs [0:16];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er,
                           output int lat, output int nr, output int nw);
        rd = '0; er = 1'b0; lat = 0; nr = 0; nw = 0;
        @(negedge clk);
        chk($sformatf("ready before %h", a), {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (dmem_ren) nr++;
            if (dmem_wen) nw++;
            if (resp_valid) begin
                rd = resp_rdata; er = resp_err; lat = c;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, nr, nw, wen_before;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h40] = 32'h8899AABB;

        //             we    f3      addr        wdata         rdata         err  lat ren wen mem
        vecs[0]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[1]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h00000088, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[2]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFF8899, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[3]  = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h0000AABB, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[4]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h8899AABB, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[5]  = '{1'b1, 3'b000, 32'h102, 32'h12345677, 32'h0,        1'b0, 3, 1, 1, 32'h8877AABB};
        vecs[6]  = '{1'b1, 3'b001, 32'h100, 32'h0000CAFE, 32'h0,        1'b0, 3, 1, 1, 32'h8877CAFE};
        vecs[7]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h8877CAFE, 1'b0, 2, 1, 0, 32'h8877CAFE};
        vecs[8]  = '{1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 3'b000, 32'h104, 32'h0,        32'hFFFFFFEF, 1'b0, 2, 1, 0, 32'hDEADBEEF};
        vecs[10] = '{1'b0, 3'b101, 32'h106, 32'h0,        32'h0000DEAD, 1'b0, 2, 1, 0, 32'hDEADBEEF};
        vecs[11] = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h8877CAFE};
        vecs[12] = '{1'b1, 3'b001, 32'h101, 32'h0000FFFF, 32'h0,        1'b1, 1, 0, 0, 32'h8877CAFE};
        vecs[13] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h8877CAFE};
        vecs[14] = '{1'b1, 3'b100, 32'h100, 32'h000000FF, 32'h0,        1'b1, 1, 0, 0, 32'h8877CAFE};
        vecs[15] = '{1'b1, 3'b010, 32'h106, 32'h11111111, 32'h0,        1'b1, 1, 0, 0, 32'hDEADBEEF};
        vecs[16] = '{1'b0, 3'b001, 32'h107, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'hDEADBEEF};

        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h100; req_wdata = '0; resp_ready = 1'b1;

        // Reset: every output low even with a request pending.
        repeat (2) @(negedge clk);
        chk("rst ctl", {27'b0, req_ready, resp_valid, resp_err, dmem_ren, dmem_wen}, 32'h0);
        chk("rst addr", dmem_addr, 32'h0);
        chk("rst rdata", resp_rdata | dmem_wdata, 32'h0);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post rst ready", {31'b0, req_ready}, 32'd1);

        foreach (vecs[i]) begin
            run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, nr, nw);
            chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d ren cycles", i), nr, vecs[i].exp_ren);
            chk($sformatf("v%0d wen cycles", i), nw, vecs[i].exp_wen);
            chk($sformatf("v%0d mem", i), mem[vecs[i].addr[9:2]], vecs[i].exp_mem);
        end

        // Backpressure on LW 0x100; a stray SW request during RESP must be ignored.
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (resp_valid) begin lat = c; break; end
        end
        chk("bp latency", lat, 32'd2);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'h0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp hold%0d valid", c), {30'b0, resp_valid, req_ready}, 32'd2);
            chk($sformatf("bp hold%0d rdata", c), resp_rdata, 32'h8877CAFE);
            chk($sformatf("bp hold%0d err", c), {31'b0, resp_err}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp release", {29'b0, resp_valid, req_ready, dmem_ren | dmem_wen}, 32'd2);
        repeat (2) @(negedge clk);
        chk("bp mem", mem[8'h40], 32'h8877CAFE);

        // Reset during the READ cycle of SB 0x100.
        wen_before = wen_total;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h100; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rmw read ren", {31'b0, dmem_ren}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rmw rst ctl", {27'b0, req_ready, resp_valid, resp_err, dmem_ren, dmem_wen}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rmw post ctl", {27'b0, req_ready, resp_valid, resp_err, dmem_ren, dmem_wen}, 32'h10);
        chk("rmw post data", dmem_addr | dmem_wdata | resp_rdata, 32'h0);
        repeat (3) @(negedge clk);
        chk("rmw wen count", wen_total - wen_before, 32'd0);
        chk("rmw mem", mem[8'h40], 32'h8877CAFE);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
